// File: rtl/bcp_pkg.sv
// Shared types and constants for the BCP implication arbiter.
package bcp_pkg;

  localparam int unsigned N_REQ     = 8;
  localparam int unsigned SRC_W     = 3;
  localparam int unsigned LIT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CONFLICT
  } arb_state_t;

  // Bits strictly below idx set: the engines that come next in descending round-robin order.
  function automatic logic [N_REQ-1:0] below_mask(input logic [SRC_W-1:0] idx);
    return (N_REQ'(1) << idx) - N_REQ'(1);
  endfunction

endpackage

// File: rtl/priority_encoder_comb.sv
// Highest-set-bit priority encoder; an all-zero input yields index 0.
module priority_encoder_comb #(
  parameter int unsigned W  = 8,
  parameter int unsigned OW = 3
) (
  input  logic [W-1:0]  vec_i,
  output logic [OW-1:0] idx_o
);

  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (vec_i[i]) idx_o = OW'(i);
    end
  end

endmodule

// File: rtl/bcp_implication_arbiter.sv
// Round-robin arbiter sharing the BCP trail-write port between eight engines,
// with conflict escalation to the solver controller.
module bcp_implication_arbiter #(
  parameter int unsigned LIT_W = bcp_pkg::LIT_W_DEF,
  parameter int unsigned N_REQ = bcp_pkg::N_REQ
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*LIT_W-1:0] req_lit,
  input  logic [N_REQ-1:0]       req_conflict,
  output logic [N_REQ-1:0]       req_ack,
  output logic                   imp_valid,
  output logic [LIT_W-1:0]       imp_lit,
  output logic [2:0]             imp_src,
  input  logic                   imp_ready,
  output logic                   conflict,
  output logic [2:0]             conflict_src,
  input  logic                   conflict_clear,
  output logic                   busy
);
  import bcp_pkg::*;

  arb_state_t       state_q, state_d;
  logic [SRC_W-1:0] last_src_q, last_src_d;
  logic [SRC_W-1:0] imp_src_q, imp_src_d;
  logic [SRC_W-1:0] conflict_src_q, conflict_src_d;
  logic [LIT_W-1:0] imp_lit_q, imp_lit_d;
  logic [N_REQ-1:0] req_ack_q, req_ack_d;
  logic             imp_valid_q, imp_valid_d;
  logic             conflict_q, conflict_d;
  logic             busy_q;

  logic [N_REQ-1:0] masked, full_vec;
  logic [SRC_W-1:0] masked_idx, full_idx, sel_idx;
  logic [LIT_W-1:0] sel_lit;
  logic             conf_any;

  assign conf_any = |req_conflict;
  assign masked   = req_valid & below_mask(last_src_q);
  // The full-vector encoder serves conflicts in IDLE, otherwise the valid vector.
  assign full_vec = (state_q == IDLE && conf_any) ? req_conflict : req_valid;

  priority_encoder_comb #(.W(N_REQ), .OW(SRC_W)) u_enc_masked (
    .vec_i (masked),
    .idx_o (masked_idx)
  );

  priority_encoder_comb #(.W(N_REQ), .OW(SRC_W)) u_enc_full (
    .vec_i (full_vec),
    .idx_o (full_idx)
  );

  assign sel_idx = (|masked) ? masked_idx : full_idx;

  always_comb begin
    sel_lit = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (sel_idx == SRC_W'(i)) sel_lit = req_lit[i*LIT_W +: LIT_W];
    end
  end

  always_comb begin
    state_d        = state_q;
    last_src_d     = last_src_q;
    imp_src_d      = imp_src_q;
    imp_lit_d      = imp_lit_q;
    imp_valid_d    = imp_valid_q;
    conflict_d     = conflict_q;
    conflict_src_d = conflict_src_q;
    req_ack_d      = '0;
    case (state_q)
      IDLE: begin
        if (conf_any) begin
          state_d        = CONFLICT;
          conflict_d     = 1'b1;
          conflict_src_d = full_idx;
        end else if (|req_valid) begin
          state_d     = ISSUE;
          imp_valid_d = 1'b1;
          imp_lit_d   = sel_lit;
          imp_src_d   = sel_idx;
          req_ack_d   = N_REQ'(1) << sel_idx;
          last_src_d  = sel_idx;
        end
      end
      ISSUE: begin
        if (imp_ready) begin
          imp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      CONFLICT: begin
        if (conflict_clear) begin
          conflict_d = 1'b0;
          last_src_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      last_src_q     <= '0;
      imp_src_q      <= '0;
      imp_lit_q      <= '0;
      imp_valid_q    <= 1'b0;
      conflict_q     <= 1'b0;
      conflict_src_q <= '0;
      req_ack_q      <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_src_q     <= last_src_d;
      imp_src_q      <= imp_src_d;
      imp_lit_q      <= imp_lit_d;
      imp_valid_q    <= imp_valid_d;
      conflict_q     <= conflict_d;
      conflict_src_q <= conflict_src_d;
      req_ack_q      <= req_ack_d;
      busy_q         <= (state_d != IDLE);
    end
  end

  assign req_ack      = req_ack_q;
  assign imp_valid    = imp_valid_q;
  assign imp_lit      = imp_lit_q;
  assign imp_src      = imp_src_q;
  assign conflict     = conflict_q;
  assign conflict_src = conflict_src_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_bcp_implication_arbiter.sv
// Scoreboard bench: the driver predicts each grant/conflict, a monitor checks DUT outputs.
module tb_bcp_implication_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   req_valid, req_conflict, req_ack;
  logic [127:0] req_lit;
  logic         imp_valid, imp_ready, conflict, conflict_clear, busy;
  logic [15:0]  imp_lit;
  logic [2:0]   imp_src, conflict_src;

  logic [15:0]  lits [8];

  typedef struct {
    int          src;
    logic [15:0] lit;
  } grant_t;

  grant_t      gq[$];
  int          cq[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int          last_m;
  int          rdy_mode;

  bcp_implication_arbiter #(.LIT_W(16), .N_REQ(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_lit        (req_lit),
    .req_conflict   (req_conflict),
    .req_ack        (req_ack),
    .imp_valid      (imp_valid),
    .imp_lit        (imp_lit),
    .imp_src        (imp_src),
    .imp_ready      (imp_ready),
    .conflict       (conflict),
    .conflict_src   (conflict_src),
    .conflict_clear (conflict_clear),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_lit = '0;
    for (int i = 0; i < 8; i++) req_lit[i*16 +: 16] = lits[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next engine in descending circular order starting just below the last grant.
  function automatic int rr_pick(input logic [7:0] pend, input int last);
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (last - k + 8) % 8;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  // Ready generator: random, forced low or forced high.
  initial begin
    imp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       imp_ready = ($urandom_range(0, 99) < 65);
        1:       imp_ready = 1'b0;
        default: imp_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT acks or raises conflict.
  initial begin
    logic        hold_v, prev_conf;
    logic [15:0] hold_lit;
    logic [2:0]  hold_src;
    grant_t      g;
    int          c;
    hold_v = 1'b0;
    prev_conf = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
        prev_conf = 1'b0;
      end else begin
        if (hold_v) begin
          check("hold_valid", imp_valid, 1);
          check("hold_lit", imp_lit, hold_lit);
          check("hold_src", imp_src, hold_src);
          check("hold_no_ack", req_ack, 0);
        end
        if (req_ack != 8'h00) begin
          if (gq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_ack: req_ack=%b with no grant expected at %0t", req_ack, $time);
          end else begin
            g = gq.pop_front();
            check("ack_onehot", req_ack, 32'(8'h01 << g.src));
            check("imp_valid", imp_valid, 1);
            check("imp_src", imp_src, g.src);
            check("imp_lit", imp_lit, g.lit);
          end
        end
        if (conflict) check("ack_in_conflict", req_ack, 0);
        if (conflict && !prev_conf) begin
          if (cq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_conflict: conflict_src=%0d with none expected", conflict_src);
          end else begin
            c = cq.pop_front();
            check("conflict_src", conflict_src, c);
            check("conflict_imp_valid", imp_valid, 0);
          end
        end
        prev_conf = conflict;
        hold_v    = imp_valid && !imp_ready;
        hold_lit  = imp_lit;
        hold_src  = imp_src;
      end
    end
  end

  task automatic do_grant(output int g);
    grant_t e;
    bit     seen;
    g = rr_pick(req_valid, last_m);
    e.src = g;
    e.lit = lits[g];
    gq.push_back(e);
    seen = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (req_ack != 8'h00) seen = 1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL grant_timeout: no req_ack for engine %0d", g);
    end
    req_valid[g] = 1'b0;
    last_m = g;
  endtask

  task automatic wait_conflict();
    bit seen;
    seen = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (conflict) seen = 1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL conflict_timeout: conflict never asserted");
    end
  endtask

  task automatic clear_conflict();
    req_conflict   = 8'h00;
    conflict_clear = 1'b1;
    last_m         = 0;
    @(posedge clk);
    #1;
    conflict_clear = 1'b0;
  endtask

  initial begin
    int g;
    rst = 1'b1;
    req_valid = '0;
    req_conflict = '0;
    conflict_clear = 1'b0;
    for (int i = 0; i < 8; i++) lits[i] = '0;
    rdy_mode = 2;
    last_m = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_imp_valid", imp_valid, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_conflict", conflict, 0);
    check("rst_imp_lit", imp_lit, 0);
    check("rst_imp_src", imp_src, 0);
    check("rst_conflict_src", conflict_src, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Round-robin from a fresh last_src, then a wrap with bit 7 re-raised.
    for (int i = 0; i < 8; i++) lits[i] = 16'($urandom);
    req_valid = 8'b1001_0010;
    do_grant(g); check("rr_src_a", imp_src, 7);
    do_grant(g); check("rr_src_b", imp_src, 4);
    req_valid[7] = 1'b1;
    do_grant(g); check("rr_src_c", imp_src, 1);
    do_grant(g); check("rr_src_d", imp_src, 7);
    @(posedge clk);
    #1;

    // Single request with immediate acceptance.
    lits[2] = 16'h0051;
    req_valid = 8'h04;
    do_grant(g);
    @(posedge clk);
    #1;
    check("single_busy_t2", busy, 0);
    check("single_valid_t2", imp_valid, 0);

    // Backpressure: no new grant while the first waits.
    rdy_mode = 1;
    lits[5] = 16'($urandom);
    req_valid = 8'h20;
    do_grant(g);
    lits[6] = 16'($urandom);
    req_valid[6] = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_no_ack", req_ack, 0);
    end
    rdy_mode = 2;
    do_grant(g);
    @(posedge clk);
    #1;

    // Conflict wins over a simultaneous request.
    lits[3] = 16'($urandom);
    req_valid = 8'h08;
    req_conflict = 8'h21;
    cq.push_back(5);
    wait_conflict();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("conf_busy", busy, 1);
    end
    begin
      grant_t e;
      e.src = 3;
      e.lit = lits[3];
      gq.push_back(e);
    end
    clear_conflict();
    check("clear_conflict_c1", conflict, 0);
    check("clear_busy_c1", busy, 0);
    @(posedge clk);
    #1;
    check("clear_grant_c2", req_ack, 8'h08);
    req_valid[3] = 1'b0;
    last_m = 3;
    @(posedge clk);
    #1;

    // Conflict raised during ISSUE waits for the handshake.
    rdy_mode = 1;
    lits[0] = 16'($urandom);
    req_valid = 8'h01;
    do_grant(g);
    req_conflict = 8'h40;
    cq.push_back(6);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("issue_no_conflict", conflict, 0);
    end
    rdy_mode = 2;
    @(posedge clk);
    #1;
    check("issue_done_valid", imp_valid, 0);
    check("issue_done_conflict", conflict, 0);
    @(posedge clk);
    #1;
    check("issue_then_conflict", conflict, 1);
    clear_conflict();
    @(posedge clk);
    #1;

    // Asynchronous reset during a grant.
    rdy_mode = 1;
    lits[1] = 16'($urandom);
    lits[4] = 16'($urandom);
    req_valid = 8'h12;
    do_grant(g);
    #2;
    rst = 1'b1;
    #1;
    check("arst_imp_valid", imp_valid, 0);
    check("arst_req_ack", req_ack, 0);
    check("arst_busy", busy, 0);
    check("arst_conflict", conflict, 0);
    gq.delete();
    cq.delete();
    last_m = 0;
    req_valid = 8'h12;
    rdy_mode = 2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_grant(g);
    check("arst_first_grant", imp_src, 4);

    // Randomized traffic with occasional conflicts.
    rdy_mode = 0;
    for (int it = 0; it < 200; it++) begin
      for (int i = 0; i < 8; i++) begin
        if (!req_valid[i] && $urandom_range(0, 99) < 30) begin
          lits[i] = 16'($urandom);
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == 8'h00) begin
        int k;
        k = $urandom_range(0, 7);
        lits[k] = 16'($urandom);
        req_valid[k] = 1'b1;
      end
      if ($urandom_range(0, 99) < 8) begin
        logic [7:0] cv;
        cv = 8'($urandom_range(1, 255));
        req_conflict = cv;
        cq.push_back(highest(cv));
        wait_conflict();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        clear_conflict();
      end else begin
        do_grant(g);
      end
    end

    rdy_mode = 2;
    req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    check("grant_queue_drained", gq.size(), 0);
    check("conflict_queue_drained", cq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

endmodule

// File: doc/bcp_implication_arbiter.md
# bcp_implication_arbiter

- Shares the single trail-write port of the hardware BCP unit between 8 clause-evaluation engines.
- Picks one pending implication per grant, round-robin, using the 8-bit priority encoder.
- Presents the chosen literal on a valid/ready output.
- Escalates any engine-reported conflict to the solver controller and holds until the conflict is cleared.

## Interface
Parameters:
- LIT_W, 16: literal width (variable index plus polarity bit, LSB = polarity).
- N_REQ, 8: number of requesting engines; fixed at 8 by the encoder width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- req_valid  in  8  per-engine implication pending. Held with req_lit stable until req_ack.
- req_lit  in  8*LIT_W  packed literals; engine i occupies bits [i*LIT_W +: LIT_W].
- req_conflict  in  8  per-engine conflict flag. Held until conflict_clear.
- req_ack  out  8  one-hot, one-cycle pulse granting engine i.
- imp_valid  out  1  implication available on imp_lit.
- imp_lit  out  LIT_W  granted literal.
- imp_src  out  3  index of the granted engine.
- imp_ready  in  1  trail port accepts the implication.
- conflict  out  1  conflict latched.
- conflict_src  out  3  index of the conflicting engine.
- conflict_clear  in  1  solver acknowledges the conflict and backtracks.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, CONFLICT.
- IDLE, any req_conflict set:
  - Go to CONFLICT.
  - conflict_src = highest set index of req_conflict.
  - Conflicts take priority over req_valid in the same cycle.
- IDLE, no conflict, any req_valid set:
  - Select engine sel by round-robin: masked = req_valid with bits [7:last_src] cleared. sel = encode(masked) if masked nonzero, else encode(req_valid). Grant order is descending, wrapping 0 -> 7.
  - Register imp_lit = req_lit[sel], imp_src = sel, imp_valid = 1, req_ack = one-hot(sel), last_src = sel.
  - Go to ISSUE.
- ISSUE:
  - Hold imp_valid, imp_lit and imp_src stable until imp_valid && imp_ready.
  - On the handshake: imp_valid = 0, go to IDLE.
  - req_valid and req_conflict are ignored in ISSUE. The outstanding implication always completes.
- CONFLICT:
  - conflict = 1; conflict_src held; requests ignored.
  - On conflict_clear: conflict = 0, last_src = 0, go to IDLE.
- All-zero request vector in IDLE: stay in IDLE with no output change.
- Reset: all outputs 0 (imp_valid, imp_lit, imp_src, req_ack, conflict, conflict_src, busy). State = IDLE, last_src = 0. Reset mid-ISSUE or mid-CONFLICT drops the pending implication or conflict immediately, with no handshake.

## Timing
- Request sampled in IDLE at cycle t: imp_valid, imp_lit and imp_src are valid from t+1. req_ack is high during t+1 only.
- The engine deasserts or updates req_valid no later than t+2.
- With imp_ready high at t+1, the handshake completes at t+1. The arbiter is in IDLE at t+2.
- Peak throughput is one implication per 2 cycles.
- Conflict seen in IDLE at t: conflict = 1 from t+1.
- conflict_clear at cycle c: IDLE at c+1, first new grant visible at c+2.
- req_ack is never asserted in CONFLICT and never for a conflict.
- All outputs are registered. No combinational input-to-output path.

## Structure
- Shared package bcp_pkg holds:
  - typedef enum arb_state_t {IDLE, ISSUE, CONFLICT};
  - localparams N_REQ = 8, SRC_W = 3;
  - LIT_W default.
- Sub-module: two instances of priority_encoder_comb.
  - One encodes the masked vector; one encodes the full req_valid. The same full-vector instance is time-shared for req_conflict via an input mux.
  - Its zero-input output of 0 is qualified with a separate any-bit (|vector).
- Wrapper holds the FSM, last_src, and the output registers.

## Test plan
- Single request: req_valid = 8'b0000_0100, lit 16'h0051, imp_ready high. Expected: imp_valid, imp_lit = 16'h0051, imp_src = 2 and req_ack = 8'h04 at t+1; busy low at t+2.
- Round-robin: req_valid = 8'b1001_0010 held, each engine dropping its bit after ack. Expected grant order 7, 4, 1. Then re-raise bit 7 together with bit 1: grant 1 then 7, confirming the wrap.
- Backpressure: imp_ready low for 5 cycles after a grant. Expected: imp_valid and imp_lit held constant, no further req_ack, a new req_valid bit not granted until after the handshake.
- Conflict priority: same IDLE cycle req_valid = 8'h08, req_conflict = 8'h21. Expected: conflict = 1 with conflict_src = 5, no req_ack, no imp_valid. conflict_clear then leads to a grant to engine 3 two cycles later.
- Conflict during ISSUE: req_conflict raised while imp_valid is waiting. Expected: implication completes on imp_ready, then conflict asserts the cycle after return to IDLE.
- Reset mid-ISSUE: assert rst asynchronously. Expected: imp_valid, req_ack, busy and conflict all 0 without waiting for a clock edge; the first grant after reset is the highest requesting index.
